// File: rtl/spi_slave_mode_if.sv
// Pin and register-file signal bundle for spi_slave_mode.
// The slave modport is the bridge; the master modport is the board and regfile side.
interface spi_slave_mode_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
);
    logic              sclk;
    logic              mosi;
    logic              ssel;
    logic              miso;
    logic              rf_wr_en;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_wr_data;
    logic [DATA_W-1:0] rf_rd_data;
    logic              busy;
    logic              frame_err;

    modport slave (
        input  sclk, mosi, ssel, rf_rd_data,
        output miso, rf_wr_en, rf_addr, rf_wr_data, busy, frame_err
    );

    modport master (
        output sclk, mosi, ssel, rf_rd_data,
        input  miso, rf_wr_en, rf_addr, rf_wr_data, busy, frame_err
    );
endinterface

// File: rtl/spi_slave_mode.sv
// SPI slave to register-file bridge, all four SPI modes, oversampled in the clk domain.
// Optional feature macro: SPI_SLAVE_BURST_EN (multi-word frames with auto-incrementing address).
module spi_slave_mode #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 4,
    parameter int CMD_W       = 16,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                nrst,
    spi_slave_mode_if.slave     bus
);

    localparam int MAX_W = (CMD_W > DATA_W) ? CMD_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA,
        WAIT
    } state_t;

    // Input synchronisers plus one history flop each for edge detection.
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] ssel_sync;
    logic                   sclk_prev;
    logic                   ssel_prev;

    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking assignments so every flop sees pre-edge values.
        if (!nrst) begin
            sclk_sync <= {SYNC_STAGES{CPOL}};
            mosi_sync <= '0;
            ssel_sync <= '1;
            sclk_prev <= CPOL;
            ssel_prev <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            ssel_sync <= {ssel_sync[SYNC_STAGES-2:0], bus.ssel};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
            ssel_prev <= ssel_sync[SYNC_STAGES-1];
        end
    end

    logic sclk_s;
    logic mosi_s;
    logic ssel_s;
    logic lead_edge;
    logic trail_edge;
    logic sample_edge;
    logic shift_edge;
    logic ssel_fall;
    logic ssel_rise;

    assign sclk_s      = sclk_sync[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync[SYNC_STAGES-1];
    assign ssel_s      = ssel_sync[SYNC_STAGES-1];
    assign lead_edge   = (sclk_s != CPOL) && (sclk_prev == CPOL);
    assign trail_edge  = (sclk_s == CPOL) && (sclk_prev != CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign ssel_fall   = ssel_prev && !ssel_s;
    assign ssel_rise   = !ssel_prev && ssel_s;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CMD_W-2:0]  cmd_sr;
    logic [DATA_W-2:0] rx_sr;
    logic [DATA_W-1:0] tx_sr;
    logic              miso_q;
    logic              is_write;
    logic              load_pending;
    logic [ADDR_W-1:0] rf_addr_q;
    logic [DATA_W-1:0] rf_wr_data_q;
    logic              rf_wr_en_q;
    logic              frame_err_q;
    logic              frame_err_d;
    logic              cmd_done;
    logic              word_done;
`ifdef SPI_SLAVE_BURST_EN
    logic              word_seen;
`endif

    logic [CMD_W-1:0]  cmd_next;
    logic [DATA_W-1:0] rx_next;
    logic              cmd_last;
    logic              data_last;

    assign cmd_next  = {cmd_sr, mosi_s};
    assign rx_next   = {rx_sr, mosi_s};
    assign cmd_last  = (bit_cnt == CNT_W'(CMD_W - 1));
    assign data_last = (bit_cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk) begin
        if (!nrst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d     = state_q;
        frame_err_d = 1'b0;
        cmd_done    = 1'b0;
        word_done   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ssel_fall) state_d = CMD;
            end
            CMD: begin
                if (ssel_rise) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end else if (sample_edge && cmd_last) begin
                    cmd_done = 1'b1;
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (ssel_rise) begin
                    state_d = IDLE;
`ifdef SPI_SLAVE_BURST_EN
                    // Deselect between words closes a burst cleanly.
                    frame_err_d = !(word_seen && (bit_cnt == '0));
`else
                    frame_err_d = 1'b1;
`endif
                end else if (sample_edge && data_last) begin
                    word_done = 1'b1;
`ifdef SPI_SLAVE_BURST_EN
                    state_d = DATA;
`else
                    state_d = WAIT;
`endif
                end
            end
            WAIT: begin
                if (ssel_rise) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            bit_cnt      <= '0;
            cmd_sr       <= '0;
            rx_sr        <= '0;
            tx_sr        <= '0;
            miso_q       <= 1'b0;
            is_write     <= 1'b0;
            load_pending <= 1'b0;
            rf_addr_q    <= '0;
            rf_wr_data_q <= '0;
            rf_wr_en_q   <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef SPI_SLAVE_BURST_EN
            word_seen    <= 1'b0;
`endif
        end else begin
            rf_wr_en_q   <= 1'b0;
            frame_err_q  <= frame_err_d;
            load_pending <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ssel_fall) begin
                        bit_cnt  <= '0;
                        cmd_sr   <= '0;
                        rx_sr    <= '0;
                        tx_sr    <= '0;
                        miso_q   <= 1'b0;
                        is_write <= 1'b0;
`ifdef SPI_SLAVE_BURST_EN
                        word_seen <= 1'b0;
`endif
                    end
                end
                CMD: begin
                    if (cmd_done) begin
                        bit_cnt      <= '0;
                        rf_addr_q    <= cmd_next[ADDR_W-1:0];
                        is_write     <= cmd_next[CMD_W-1];
                        load_pending <= !cmd_next[CMD_W-1];
                    end else if (sample_edge) begin
                        cmd_sr  <= cmd_next[CMD_W-2:0];
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DATA: begin
                    // rf_addr settled last clk, so rf_rd_data is the addressed word.
                    if (load_pending) tx_sr <= bus.rf_rd_data;
                    if (shift_edge && !is_write) begin
                        miso_q <= tx_sr[DATA_W-1];
                        tx_sr  <= {tx_sr[DATA_W-2:0], 1'b0};
                    end
                    if (word_done) begin
                        bit_cnt <= '0;
                        if (is_write) begin
                            rf_wr_en_q   <= 1'b1;
                            rf_wr_data_q <= rx_next;
                        end
`ifdef SPI_SLAVE_BURST_EN
                        rf_addr_q    <= rf_addr_q + 1'b1;
                        word_seen    <= 1'b1;
                        load_pending <= !is_write;
`endif
                    end else if (sample_edge) begin
                        rx_sr   <= rx_next[DATA_W-2:0];
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // miso is also gated by the raw select pin so it drops as soon as the master deselects.
    assign bus.miso       = (state_q == DATA) && !is_write && !bus.ssel && miso_q;
    assign bus.busy       = !ssel_s && (state_q != IDLE);
    assign bus.rf_wr_en   = rf_wr_en_q;
    assign bus.rf_addr    = rf_addr_q;
    assign bus.rf_wr_data = rf_wr_data_q;
    assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_spi_slave_mode.sv
// Directed bench for spi_slave_mode: one instance per SPI mode, shared bit-banged master task.
// Build with SPI_SLAVE_BURST_EN defined to exercise burst frames.
module tb_spi_slave_mode;

    localparam int HALF = 8;

    logic clk;
    logic nrst;

    logic [3:0]  sclk_pin;
    logic [3:0]  mosi_pin;
    logic [3:0]  ssel_pin;
    logic [3:0]  rd_force_en;
    logic [15:0] rd_force [4];

    wire  [3:0]  miso_pin;
    wire  [3:0]  wr_en_pin;
    wire  [3:0]  busy_pin;
    wire  [3:0]  ferr_pin;
    wire  [3:0]  addr_pin  [4];
    wire  [15:0] wdata_pin [4];

    logic [15:0] regs [4][16];
    int          wr_cnt   [4];
    int          ferr_cnt [4];
    logic [3:0]  last_addr [4];
    logic [15:0] last_data [4];

    int n_tests = 0;
    int n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_mode
        spi_slave_mode_if #(.ADDR_W(4), .DATA_W(16)) bus ();

        assign bus.sclk       = sclk_pin[g];
        assign bus.mosi       = mosi_pin[g];
        assign bus.ssel       = ssel_pin[g];
        assign bus.rf_rd_data = rd_force_en[g] ? rd_force[g] : regs[g][bus.rf_addr];
        assign miso_pin[g]    = bus.miso;
        assign wr_en_pin[g]   = bus.rf_wr_en;
        assign busy_pin[g]    = bus.busy;
        assign ferr_pin[g]    = bus.frame_err;
        assign addr_pin[g]    = bus.rf_addr;
        assign wdata_pin[g]   = bus.rf_wr_data;

        spi_slave_mode #(
            .DATA_W(16), .ADDR_W(4), .CMD_W(16),
            .CPOL(g >= 2), .CPHA(g % 2 == 1), .SYNC_STAGES(2)
        ) u_dut (
            .clk  (clk),
            .nrst (nrst),
            .bus  (bus)
        );
    end

    // Regfile model plus per-cycle strobe counters (a 1-clk pulse counts exactly once).
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (wr_en_pin[k]) begin
                regs[k][addr_pin[k]] <= wdata_pin[k];
                last_addr[k]         <= addr_pin[k];
                last_data[k]         <= wdata_pin[k];
                wr_cnt[k]            <= wr_cnt[k] + 1;
            end
            if (ferr_pin[k]) ferr_cnt[k] <= ferr_cnt[k] + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic half_period();
        repeat (HALF) @(negedge clk);
    endtask

    // Master for mode k (CPOL = k[1], CPHA = k[0]): 16 command bits then nbits data bits.
    task automatic spi_xfer(input int k, input logic [15:0] cmd, input logic [31:0] dat,
                            input int nbits, input bit release_sel,
                            output logic [31:0] rx, output logic cmd_miso, output logic busy_end);
        logic [47:0] stream;
        int          total;
        bit          cpol;
        bit          cpha;
        stream   = {cmd, dat};
        total    = 16 + nbits;
        cpol     = k[1];
        cpha     = k[0];
        rx       = '0;
        cmd_miso = 1'b0;
        sclk_pin[k] = cpol;
        ssel_pin[k] = 1'b0;
        if (!cpha) mosi_pin[k] = stream[47];
        half_period();
        for (int i = 0; i < total; i++) begin
            sclk_pin[k] = !cpol;
            if (cpha) mosi_pin[k] = stream[47-i];
            else if (i < 16) cmd_miso = cmd_miso | miso_pin[k];
            else rx = {rx[30:0], miso_pin[k]};
            half_period();
            sclk_pin[k] = cpol;
            if (cpha) begin
                if (i < 16) cmd_miso = cmd_miso | miso_pin[k];
                else rx = {rx[30:0], miso_pin[k]};
            end else if (i + 1 < total) begin
                mosi_pin[k] = stream[46-i];
            end
            half_period();
        end
        busy_end = busy_pin[k];
        if (release_sel) begin
            ssel_pin[k] = 1'b1;
            mosi_pin[k] = 1'b0;
            half_period();
            half_period();
        end
    endtask

    initial begin
        #600_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rx;
        logic        cm;
        logic        be;
        int          wr0;
        int          fe0;
        logic [3:0]  t3_addr [4];
        logic [15:0] t3_dat  [4];

        t3_addr[1] = 4'h6; t3_dat[1] = 16'hC33C;
        t3_addr[2] = 4'hC; t3_dat[2] = 16'h7E81;
        t3_addr[3] = 4'hA; t3_dat[3] = 16'h0F0F;
        t3_addr[0] = 4'h0; t3_dat[0] = 16'h0000;

        nrst        = 1'b0;
        sclk_pin    = 4'b1100;
        mosi_pin    = 4'b0000;
        ssel_pin    = 4'b1111;
        rd_force_en = 4'b0000;
        for (int k = 0; k < 4; k++) rd_force[k] = 16'h0;
        repeat (4) @(negedge clk);
        check("rst_flags", {16'h0, wr_en_pin, busy_pin, ferr_pin, miso_pin}, 32'h0);
        check("rst_addr0", {28'h0, addr_pin[0]}, 32'h0);
        check("rst_wdata0", {16'h0, wdata_pin[0]}, 32'h0);
        nrst = 1'b1;
        repeat (6) @(negedge clk);
        check("idle_flags", {16'h0, wr_en_pin, busy_pin, ferr_pin, miso_pin}, 32'h0);

        // 1: mode 0 single write
        wr0 = wr_cnt[0]; fe0 = ferr_cnt[0];
        spi_xfer(0, 16'h8003, {16'hA5C3, 16'h0}, 16, 1'b1, rx, cm, be);
        check("t1_wr_pulses", wr_cnt[0] - wr0, 1);
        check("t1_wr_addr", {28'h0, last_addr[0]}, 32'h3);
        check("t1_wr_data", {16'h0, last_data[0]}, 32'hA5C3);
        check("t1_rf_addr", {28'h0, addr_pin[0]}, 32'h3);
        check("t1_busy_wait", {31'h0, be}, 32'h1);
        check("t1_cmd_miso", {31'h0, cm}, 32'h0);
        check("t1_ferr", ferr_cnt[0] - fe0, 0);
        check("t1_busy_idle", {31'h0, busy_pin[0]}, 32'h0);

        // 2: mode 0 read with forced regfile data, 32 clocks after the command
        rd_force[0] = 16'h1234; rd_force_en[0] = 1'b1;
        wr0 = wr_cnt[0]; fe0 = ferr_cnt[0];
        spi_xfer(0, 16'h0005, 32'h0, 32, 1'b1, rx, cm, be);
`ifdef SPI_SLAVE_BURST_EN
        check("t2_rx", rx, 32'h1234_1234);
        check("t2_rf_addr", {28'h0, addr_pin[0]}, 32'h7);
`else
        check("t2_rx", rx, 32'h1234_0000);
        check("t2_rf_addr", {28'h0, addr_pin[0]}, 32'h5);
`endif
        check("t2_no_write", wr_cnt[0] - wr0, 0);
        check("t2_ferr", ferr_cnt[0] - fe0, 0);
        check("t2_cmd_miso", {31'h0, cm}, 32'h0);
        check("t2_miso_idle", {31'h0, miso_pin[0]}, 32'h0);
        rd_force_en[0] = 1'b0;

        // 3: remaining modes, write then read back through the regfile model
        for (int k = 1; k < 4; k++) begin
            wr0 = wr_cnt[k];
            spi_xfer(k, {12'h800, t3_addr[k]}, {t3_dat[k], 16'h0}, 16, 1'b1, rx, cm, be);
            spi_xfer(k, {12'h000, t3_addr[k]}, 32'h0, 16, 1'b1, rx, cm, be);
            check($sformatf("t3_m%0d_readback", k), {16'h0, rx[15:0]}, {16'h0, t3_dat[k]});
            check($sformatf("t3_m%0d_wr_pulses", k), wr_cnt[k] - wr0, 1);
        end

        // 4: sclk with ssel high is ignored, then an aborted write, then a clean one
        wr0 = wr_cnt[0]; fe0 = ferr_cnt[0];
        for (int i = 0; i < 3; i++) begin
            sclk_pin[0] = 1'b1; half_period();
            sclk_pin[0] = 1'b0; half_period();
        end
        check("t4_ignore_busy", {31'h0, busy_pin[0]}, 32'h0);
        spi_xfer(0, 16'h8002, {16'hFFFF, 16'h0}, 10, 1'b1, rx, cm, be);
        check("t4_abort_ferr", ferr_cnt[0] - fe0, 1);
        check("t4_abort_no_wr", wr_cnt[0] - wr0, 0);
        check("t4_abort_busy", {31'h0, busy_pin[0]}, 32'h0);
        fe0 = ferr_cnt[0];
        spi_xfer(0, 16'h8002, {16'h5A5A, 16'h0}, 16, 1'b1, rx, cm, be);
        check("t4_next_wr", wr_cnt[0] - wr0, 1);
        check("t4_next_data", {16'h0, last_data[0]}, 32'h5A5A);
        check("t4_next_ferr", ferr_cnt[0] - fe0, 0);

        // 5: reset mid-DATA aborts silently
        wr0 = wr_cnt[0]; fe0 = ferr_cnt[0];
        spi_xfer(0, 16'h8007, {16'hDEAD, 16'h0}, 10, 1'b0, rx, cm, be);
        check("t5_busy_before", {31'h0, busy_pin[0]}, 32'h1);
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_rst_flags", {28'h0, wr_en_pin[0], busy_pin[0], ferr_pin[0], miso_pin[0]}, 32'h0);
        check("t5_rst_addr", {28'h0, addr_pin[0]}, 32'h0);
        check("t5_rst_wdata", {16'h0, wdata_pin[0]}, 32'h0);
        ssel_pin[0] = 1'b1; sclk_pin[0] = 1'b0; mosi_pin[0] = 1'b0;
        repeat (6) @(negedge clk);
        nrst = 1'b1;
        repeat (10) @(negedge clk);
        check("t5_no_ferr", ferr_cnt[0] - fe0, 0);
        check("t5_no_wr", wr_cnt[0] - wr0, 0);
        spi_xfer(0, 16'h8001, {16'hBEEF, 16'h0}, 16, 1'b1, rx, cm, be);
        check("t5_wr_pulses", wr_cnt[0] - wr0, 1);
        check("t5_wr_addr", {28'h0, last_addr[0]}, 32'h1);
        check("t5_wr_data", {16'h0, last_data[0]}, 32'hBEEF);

`ifdef SPI_SLAVE_BURST_EN
        // 6: burst write wrapping 15 -> 0, burst readback, mid-word abort
        wr0 = wr_cnt[0]; fe0 = ferr_cnt[0];
        spi_xfer(0, 16'h800F, 32'h1111_2222, 32, 1'b1, rx, cm, be);
        check("t6_wr_pulses", wr_cnt[0] - wr0, 2);
        check("t6_reg15", {16'h0, regs[0][15]}, 32'h1111);
        check("t6_reg0", {16'h0, regs[0][0]}, 32'h2222);
        check("t6_rf_addr", {28'h0, addr_pin[0]}, 32'h1);
        check("t6_ferr", ferr_cnt[0] - fe0, 0);
        spi_xfer(0, 16'h000F, 32'h0, 32, 1'b1, rx, cm, be);
        check("t6_readback", rx, 32'h1111_2222);
        wr0 = wr_cnt[0]; fe0 = ferr_cnt[0];
        spi_xfer(0, 16'h8005, 32'hAAAA_BBBB, 24, 1'b1, rx, cm, be);
        check("t6_abort_wr", wr_cnt[0] - wr0, 1);
        check("t6_abort_ferr", ferr_cnt[0] - fe0, 1);
        check("t6_abort_reg5", {16'h0, regs[0][5]}, 32'hAAAA);
`else
        // 6: extra clocks after a single-word write are ignored in WAIT
        wr0 = wr_cnt[0]; fe0 = ferr_cnt[0];
        spi_xfer(0, 16'h8009, 32'h3C3C_FFFF, 32, 1'b1, rx, cm, be);
        check("t6_single_wr", wr_cnt[0] - wr0, 1);
        check("t6_single_data", {16'h0, last_data[0]}, 32'h3C3C);
        check("t6_single_ferr", ferr_cnt[0] - fe0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
